// File: rtl/snake_dir_input.sv
// Debounces three active-low direction buttons, decodes them into direction codes and queues
// accepted commands for the game core. Define SNAKE_DIR_REVERSE_FILTER_EN to also reject reversals.
module snake_dir_input #(
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter int          DEPTH           = 2,
  parameter logic [1:0]  INIT_DIR        = 2'b11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] button,
  input  logic       dir_ready,
  output logic       dir_valid,
  output logic [1:0] dir_code,
  output logic [1:0] last_dir,
  output logic [3:0] q_level,
  output logic       dropped
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam int            PW      = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    DEPTH_L = 4'(DEPTH);
  localparam logic [2:0]    NONE    = 3'b100;

  logic [2:0]    sync_a;
  logic [2:0]    sync_b;
  logic [2:0]    deb;
  logic [CW-1:0] cnt [3];
  logic [2:0]    pressed;
  logic [2:0]    dec_next;
  logic [2:0]    dec;
  logic [2:0]    dec_prev;
  logic          ev;
  logic [1:0]    ev_code;
  logic          reject;
  logic          accept;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [1:0]    head_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 3'b111;
      sync_b <= 3'b111;
    end else begin
      sync_a <= button;
      sync_b <= sync_a;
    end
  end

  // A pending change in sync_a means sync_b is about to move, so the run restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= 3'b111;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] == deb[i] || sync_a[i] != sync_b[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= sync_b[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign pressed = ~deb;

  // Decode is {none_flag, code}; multi-press and no-press both map to NONE.
  always_comb begin
    dec_next = NONE;
    unique case (pressed)
      3'b100:  dec_next = 3'b010;
      3'b010:  dec_next = 3'b001;
      3'b001:  dec_next = 3'b011;
      default: dec_next = NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec      <= NONE;
      dec_prev <= NONE;
    end else begin
      dec      <= dec_next;
      dec_prev <= dec;
    end
  end

  assign ev      = (dec != dec_prev) && !dec[2];
  assign ev_code = dec[1:0];

`ifdef SNAKE_DIR_REVERSE_FILTER_EN
  assign reject = (ev_code == last_dir) || (ev_code == (last_dir ^ 2'b10));
`else
  assign reject = (ev_code == last_dir);
`endif

  assign accept    = ev && !reject;
  assign dir_valid = (q_level != 4'd0);
  assign full      = (q_level == DEPTH_L);
  assign pop       = dir_valid && dir_ready;
  assign push      = accept && (!full || pop);
  assign drop      = accept && full && !pop;
  assign dir_code  = dir_valid ? mem[rd_ptr] : head_hold;

  // head_hold keeps the last popped entry visible while the queue is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 2'b00;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q_level   <= 4'd0;
      head_hold <= 2'b00;
      last_dir  <= INIT_DIR;
      dropped   <= 1'b0;
    end else begin
      dropped <= drop;
      if (push) begin
        mem[wr_ptr] <= ev_code;
        wr_ptr      <= wr_ptr + 1'b1;
        last_dir    <= ev_code;
      end
      if (pop) begin
        head_hold <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   q_level <= q_level + 4'd1;
        2'b01:   q_level <= q_level - 4'd1;
        default: q_level <= q_level;
      endcase
    end
  end

endmodule
